dadda_final_adder_pipe: RTL
===========================

// Module: dadda_final_adder_pipe
// PURPOSE
//  Final carry-propagate stage of the 6x6 Dadda multiplier. Consumes the two
//  11-bit rows from the reduction stage and produces the 12-bit product.
//  Two-stage pipeline: low slice in stage 1, high slice plus carry in stage 2.
//  Valid/ready handshake on both sides so upstream can be stalled.
// PARAMETERS
//  ROW_W       11  width of each input row (bits 0..10)
//  PROD_W      12  product width (ROW_W+1)
//  SPLIT        6  bits summed in stage 1 (row bits [SPLIT-1:0]); rest in stage 2
//  APPROX_BITS  3  LSBs approximated when APPROX_LSB_EN is defined; must be < SPLIT
// PORTS
//  clk        in   1       clock, all flops on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       row0/row1 hold a valid operand pair
//  in_ready   out  1       block accepts the pair this cycle
//  row0       in   ROW_W   sum row from reduction stage
//  row1       in   ROW_W   carry row from reduction stage
//  out_valid  out  1       product is valid
//  out_ready  in   1       downstream accepts product this cycle
//  product    out  PROD_W  row0 + row1 (exact or approximate, see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge): s1_valid=0, s2_valid=0, so out_valid=0; product=0;
//   in_ready=1 from the first cycle after reset. Reset mid-operation drops
//   in-flight data. No partial product is emitted.
//  Transfers: input when in_valid&in_ready; output when out_valid&out_ready.
//  Stage 1 register: low sum of SPLIT bits, carry c1, and high bits of row0/row1.
//   This register loads on an input transfer.
//  Stage 2 register: product = {high_sum(ROW_W-SPLIT+1 bits), low_sum}.
//   The high sum is row0[hi] + row1[hi] + c1.
//  Advance rules:
//   s2_load   = s1_valid & (!s2_valid | out_ready)
//   in_ready  = !s1_valid | s2_load      (combinational; no in_valid->in_ready path)
//   out_valid = s2_valid; product is held stable while out_valid & !out_ready.
//  Latency: 2 cycles from input transfer to out_valid, with out_ready held 1.
//   Throughput is 1 per cycle.
//  Simultaneous accept and emit in one cycle: both stages update; no bubble.
//  Full (both stages valid, out_ready=0): in_ready=0 and all registers hold.
//  Empty: out_valid=0; product holds its last value (don't-care to consumers).
//  Width rule: the product MSB is the carry out of the high slice. Overflow is
//   impossible for legal 6x6 inputs (max 3969 = 12'hF81).
// CONFIGURATION
//  APPROX_LSB_EN defined:
//   - product[APPROX_BITS-1:0] = row0 | row1 on those bits.
//   - No carry from the approximate bits into bit APPROX_BITS.
//   - Exact addition resumes from bit APPROX_BITS with carry-in 0.
//  APPROX_LSB_EN undefined: exact addition over all bits; APPROX_BITS is ignored.
//  Timing and handshake are identical in both builds.
// STRUCTURE
//  Package mult6_pkg:
//   - ROW_W, PROD_W constants
//   - typedef logic [ROW_W-1:0] row_t
//   - typedef logic [PROD_W-1:0] prod_t
//   Shared with reduction_stage_dadda wrappers.
//  One sub-module, cla_slice #(W):
//   - W-bit carry-lookahead adder: a, b, cin -> sum, cout.
//   - Instantiated once per stage.
//   - Approx OR logic stays in the top level under the macro.
// TESTING
//  1 Reset: rst=1 for 3 cycles with in_valid=1 -> out_valid=0 throughout;
//    in_ready=1 on the cycle after rst falls.
//  2 Exact: row0=2047, row1=1922, out_ready=1 -> product=12'hF81 (3969),
//    out_valid exactly 2 cycles after accept.
//  3 Streaming: 8 back-to-back random pairs, out_ready=1 -> 8 products, in
//    order, on consecutive cycles, each = row0+row1.
//  4 Backpressure: out_ready=0 and offer 3 pairs -> 2 accepted, in_ready=0 on
//    the 3rd. Then out_ready=1 -> 3 products in order with no loss or duplicate.
//  5 Carry boundary: row0=11'h03F, row1=11'h001 -> product=12'h040 (exact build).
//    Approx build with APPROX_BITS=3 -> 12'h03F.
//  6 Mid-op reset: assert rst while both stages are valid -> out_valid=0 next
//    cycle. The next input then yields only its own product.

Source files
------------

// File: rtl/mult6_pkg.sv
// Shared types and constants for the 6x6 Dadda multiplier datapath.
// APPROX_BITS only matters when the top is built with APPROX_LSB_EN.
package mult6_pkg;

  localparam int ROW_W       = 11;
  localparam int PROD_W      = ROW_W + 1;
  localparam int SPLIT       = 6;
  localparam int HI_W        = ROW_W - SPLIT;
  localparam int APPROX_BITS = 3;

  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [PROD_W-1:0] prod_t;

  // Stage 1 holds the finished low slice and the untouched high halves of both rows.
  typedef struct packed {
    logic [SPLIT-1:0] lo_sum;
    logic             c1;
    logic [HI_W-1:0]  hi0;
    logic [HI_W-1:0]  hi1;
  } s1_t;

endpackage

// File: rtl/dadda_final_adder_pipe_if.sv
// Operand/product handshake bundle between the reduction stage, the final adder
// and its consumer.
interface dadda_final_adder_pipe_if;
  import mult6_pkg::*;

  logic  in_valid;
  logic  in_ready;
  row_t  row0;
  row_t  row1;
  logic  out_valid;
  logic  out_ready;
  prod_t product;

  modport master (
    output in_valid, row0, row1, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, row0, row1, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/cla_slice.sv
// W-bit carry-lookahead adder: every carry is a flat sum of products of the
// generate/propagate terms and cin, not a ripple chain.
module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   carry;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin : lookahead
    logic term;
    logic run_p;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      term  = g[i];
      run_p = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term  = term | (run_p & g[j]);
        run_p = run_p & p[j];
      end
      carry[i+1] = term | (run_p & cin);
    end
  end

  assign sum  = p ^ carry[W-1:0];
  assign cout = carry[W];

endmodule

// File: rtl/dadda_final_adder_pipe.sv
// Two-stage final carry-propagate adder of the 6x6 Dadda multiplier with valid/ready
// on both sides. Define APPROX_LSB_EN to OR (not add) the lowest APPROX_BITS bits.
module dadda_final_adder_pipe
  import mult6_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  dadda_final_adder_pipe_if.slave bus
);

  s1_t              s1_q;
  s1_t              s1_d;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_load;
  logic             in_xfer;
  prod_t            product_q;
  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;

  assign s2_load       = s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready  = ~s1_valid | s2_load;
  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.product   = product_q;

`ifdef APPROX_LSB_EN
  // Approximate LSBs never carry; the exact part of the low slice starts at carry-in 0.
  logic [SPLIT-APPROX_BITS-1:0] lo_exact;

  cla_slice #(.W(SPLIT - APPROX_BITS)) u_lo (
    .a    (bus.row0[SPLIT-1:APPROX_BITS]),
    .b    (bus.row1[SPLIT-1:APPROX_BITS]),
    .cin  (1'b0),
    .sum  (lo_exact),
    .cout (lo_cout)
  );

  assign lo_sum = {lo_exact, bus.row0[APPROX_BITS-1:0] | bus.row1[APPROX_BITS-1:0]};
`else
  cla_slice #(.W(SPLIT)) u_lo (
    .a    (bus.row0[SPLIT-1:0]),
    .b    (bus.row1[SPLIT-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );
`endif

  assign s1_d.lo_sum = lo_sum;
  assign s1_d.c1     = lo_cout;
  assign s1_d.hi0    = bus.row0[ROW_W-1:SPLIT];
  assign s1_d.hi1    = bus.row1[ROW_W-1:SPLIT];

  cla_slice #(.W(HI_W)) u_hi (
    .a    (s1_q.hi0),
    .b    (s1_q.hi1),
    .cin  (s1_q.c1),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_q      <= '0;
      product_q <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      // The high-slice carry out is the product MSB.
      if (s2_load) begin
        s2_valid  <= 1'b1;
        product_q <= {hi_cout, hi_sum, s1_q.lo_sum};
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule
